// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker
//   Downstream checker for the 4-bit maximal-length pattern generator
//   (next word {s[0]^s[1], s[3:1]}, period 15). It acquires lock on the
//   incoming word stream, then flywheels a local prediction. It counts
//   mismatches while locked and measures the sequence period.
//
// Ports
//   clk          in   single clock, all state changes on posedge
//   reset        in   synchronous, active-high, clears all state
//   in_valid     in   in_data carries a sample this cycle
//   in_data      in   [3:0] generator word
//   state        out  [1:0] 00 SEARCH, 01 SYNC, 10 LOCKED
//   locked       out  high while state is LOCKED
//   err_pulse    out  one-cycle pulse per counted (LOCKED) error
//   err_count    out  [ERR_CNT_W-1:0] LOCKED errors since reset, saturating
//   period       out  [3:0] last measured sequence period
//   period_valid out  one-cycle pulse when period updates
module lfsr_seq_checker #(
    parameter int unsigned SYNC_MATCHES = 4,
    parameter int unsigned LOSS_ERRORS  = 3,
    parameter int unsigned ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [3:0]           in_data,
    output logic [1:0]           state,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [3:0]           period,
    output logic                 period_valid
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'b00,
        ST_SYNC   = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    localparam logic [3:0] SYNC_TGT = 4'(SYNC_MATCHES);
    localparam logic [3:0] LOSS_TGT = 4'(LOSS_ERRORS);

    state_t     cur_state;
    state_t     nxt_state;

    logic [3:0] pred;      // expected next sample
    logic [3:0] mcnt;      // matches seen in SYNC
    logic [3:0] ecnt;      // consecutive errors in LOCKED
    logic [3:0] ref_word;  // word captured at lock, marks the period start
    logic [3:0] pcnt;      // samples since ref_word was last seen

    logic       match;
    logic       data_zero;
    logic       sync_done;
    logic       loss;
    logic [3:0] mcnt_inc;
    logic [3:0] ecnt_inc;
    logic [3:0] pcnt_inc;

    function automatic logic [3:0] nxt(input logic [3:0] x);
        return {x[0] ^ x[1], x[3:1]};
    endfunction

    assign match     = (in_data == pred);
    assign data_zero = (in_data == 4'd0);
    assign mcnt_inc  = mcnt + 4'd1;
    assign ecnt_inc  = ecnt + 4'd1;
    assign pcnt_inc  = pcnt + 4'd1;
    assign sync_done = match && (mcnt_inc == SYNC_TGT);
    assign loss      = !match && (ecnt_inc == LOSS_TGT);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= ST_SEARCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic
    always_comb begin
        nxt_state = cur_state;
        if (in_valid) begin
            case (cur_state)
                ST_SEARCH: begin
                    if (!data_zero) nxt_state = ST_SYNC;
                end
                ST_SYNC: begin
                    // pred is never zero here, so a zero sample is always a mismatch
                    if (sync_done)                nxt_state = ST_LOCKED;
                    else if (!match && data_zero) nxt_state = ST_SEARCH;
                end
                ST_LOCKED: begin
                    if (loss) nxt_state = ST_SEARCH;
                end
                default: nxt_state = ST_SEARCH;
            endcase
        end
    end

    // Output decode
    always_comb begin
        state  = cur_state;
        locked = (cur_state == ST_LOCKED);
    end

    // Prediction, counters and registered pulse outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            pred         <= '0;
            mcnt         <= '0;
            ecnt         <= '0;
            ref_word     <= '0;
            pcnt         <= '0;
            err_pulse    <= 1'b0;
            err_count    <= '0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            err_pulse    <= 1'b0;
            period_valid <= 1'b0;
            if (in_valid) begin
                case (cur_state)
                    ST_SEARCH: begin
                        if (!data_zero) begin
                            pred <= nxt(in_data);
                            mcnt <= '0;
                        end
                    end
                    ST_SYNC: begin
                        if (match) begin
                            pred <= nxt(in_data);
                            if (sync_done) begin
                                ecnt     <= '0;
                                ref_word <= in_data;
                                pcnt     <= '0;
                            end else begin
                                mcnt <= mcnt_inc;
                            end
                        end else if (!data_zero) begin
                            // reseed on the new word rather than falling back to SEARCH
                            pred <= nxt(in_data);
                            mcnt <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        // flywheel: the prediction never follows the input once locked
                        pred <= nxt(pred);
                        if (match) begin
                            ecnt <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
                            if (loss) begin
                                ecnt <= '0;
                                mcnt <= '0;
                            end else begin
                                ecnt <= ecnt_inc;
                            end
                        end
                        if (in_data == ref_word) begin
                            period       <= pcnt_inc;
                            period_valid <= 1'b1;
                            pcnt         <= '0;
                        end else if (pcnt_inc == 4'd15) begin
                            pcnt <= '0;
                        end else begin
                            pcnt <= pcnt_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker: lock, period, single error, gaps,
// reset mid-lock, loss of lock, SYNC reseed and error-counter saturation.
module tb_lfsr_seq_checker;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic [1:0] state;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [3:0] period;
    logic       period_valid;

    int unsigned total;
    int unsigned passed;
    int unsigned failed;

    logic [3:0] seq [15];

    lfsr_seq_checker #(
        .SYNC_MATCHES(4),
        .LOSS_ERRORS (3),
        .ERR_CNT_W   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .state       (state),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_count   (err_count),
        .period      (period),
        .period_valid(period_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    function automatic logic [3:0] w(input int unsigned i);
        return seq[i % 15];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int unsigned idx;
        int unsigned gap;

        total  = 0;
        passed = 0;
        failed = 0;

        // sequence from seed 0001 under {s0^s1, s3:1}
        seq[0]  = 4'h1; seq[1]  = 4'h8; seq[2]  = 4'h4; seq[3]  = 4'h2;
        seq[4]  = 4'h9; seq[5]  = 4'hC; seq[6]  = 4'h6; seq[7]  = 4'hB;
        seq[8]  = 4'h5; seq[9]  = 4'hA; seq[10] = 4'hD; seq[11] = 4'hE;
        seq[12] = 4'hF; seq[13] = 4'h7; seq[14] = 4'h3;

        // reset with a valid sample present; the sample must be discarded
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'h1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst_state",        32'(state),        0);
        chk("rst_locked",       32'(locked),       0);
        chk("rst_err_pulse",    32'(err_pulse),    0);
        chk("rst_err_count",    32'(err_count),    0);
        chk("rst_period",       32'(period),       0);
        chk("rst_period_valid", 32'(period_valid), 0);

        // lock
        send(4'h1); chk("lock_s1_state", 32'(state), 1);
                    chk("lock_s1_locked", 32'(locked), 0);
        send(4'h8); chk("lock_s2_state", 32'(state), 1);
        send(4'h4); chk("lock_s3_state", 32'(state), 1);
        send(4'h2); chk("lock_s4_state", 32'(state), 1);
                    chk("lock_s4_locked", 32'(locked), 0);
        send(4'h9); chk("lock_s5_state", 32'(state), 2);
                    chk("lock_s5_locked", 32'(locked), 1);
                    chk("lock_err_count", 32'(err_count), 0);
        idx = 5;

        // period: ref=1001, pulse on the 15th sample after it, twice
        for (int k = 0; k < 30; k++) begin
            send(w(idx));
            idx++;
            chk("period_valid", 32'(period_valid), 32'((k == 14) || (k == 29)));
            chk("period_err_pulse", 32'(err_pulse), 0);
            if ((k == 14) || (k == 29)) chk("period_value", 32'(period), 15);
        end

        // single error: 0000 in place of 1100
        send(4'h0);
        idx++;
        chk("single_err_pulse", 32'(err_pulse), 1);
        chk("single_err_count", 32'(err_count), 1);
        chk("single_locked",    32'(locked),    1);
        for (int k = 0; k < 5; k++) begin
            send(w(idx));
            idx++;
            chk("after_err_pulse", 32'(err_pulse), 0);
            chk("after_err_count", 32'(err_count), 1);
        end

        // gaps in in_valid are transparent
        for (int k = 0; k < 4; k++) begin
            send(w(idx));
            idx++;
            chk("gap_err_pulse", 32'(err_pulse), 0);
            gap = $urandom_range(1, 5);
            idle(gap);
            chk("gap_idle_err_pulse", 32'(err_pulse), 0);
            chk("gap_locked",         32'(locked),    1);
            chk("gap_err_count",      32'(err_count), 1);
        end

        // second error, then recover: err_count=2, still locked
        send(~w(idx));
        idx++;
        chk("err2_pulse", 32'(err_pulse), 1);
        chk("err2_count", 32'(err_count), 2);
        send(w(idx));
        idx++;
        chk("err2_recover_pulse",  32'(err_pulse), 0);
        chk("err2_recover_locked", 32'(locked),    1);

        // reset mid-lock with a valid sample present
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = w(idx);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("midrst_state",        32'(state),        0);
        chk("midrst_locked",       32'(locked),       0);
        chk("midrst_err_pulse",    32'(err_pulse),    0);
        chk("midrst_err_count",    32'(err_count),    0);
        chk("midrst_period",       32'(period),       0);
        chk("midrst_period_valid", 32'(period_valid), 0);
        idle(2);
        chk("midrst_idle_state", 32'(state), 0);

        // relock, then three consecutive wrong nonzero samples
        send(4'h1); chk("relock_s1_state", 32'(state), 1);
        send(4'h8);
        send(4'h4);
        send(4'h2);
        send(4'h9); chk("relock_locked", 32'(locked), 1);
        send(4'hF); chk("loss1_count", 32'(err_count), 1);
                    chk("loss1_state", 32'(state), 2);
        send(4'hF); chk("loss2_count", 32'(err_count), 2);
                    chk("loss2_state", 32'(state), 2);
        send(4'hF); chk("loss3_count", 32'(err_count), 3);
                    chk("loss3_pulse", 32'(err_pulse), 1);
                    chk("loss3_state", 32'(state), 0);
                    chk("loss3_locked", 32'(locked), 0);
        idle(1);
        chk("loss_idle_pulse", 32'(err_pulse), 0);
        chk("loss_retained",   32'(err_count), 3);

        // SYNC reseed: 0101 mismatch reseeds pred=1010, mcnt=0, no error
        send(4'h1); chk("resync_state", 32'(state), 1);
        send(4'h8); chk("resync_m1_state", 32'(state), 1);
        send(4'h5); chk("reseed_state", 32'(state), 1);
                    chk("reseed_pulse", 32'(err_pulse), 0);
                    chk("reseed_count", 32'(err_count), 3);
        send(4'hA); chk("reseed_m1_state", 32'(state), 1);
        send(4'hD); chk("reseed_m2_state", 32'(state), 1);
        send(4'hE); chk("reseed_m3_state", 32'(state), 1);
        send(4'hF); chk("reseed_lock_state", 32'(state), 2);
                    chk("reseed_lock_pulse", 32'(err_pulse), 0);
        idx = 13;

        // alternating error/match keeps lock and drives err_count to saturation
        for (int k = 0; k < 260; k++) begin
            send(~w(idx));
            idx++;
            send(w(idx));
            idx++;
        end
        chk("sat_count",  32'(err_count), 255);
        chk("sat_locked", 32'(locked),    1);
        send(~w(idx));
        idx++;
        chk("sat_extra_pulse", 32'(err_pulse), 1);
        chk("sat_extra_count", 32'(err_count), 255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
